// File: rtl/noc_pkg.sv
// Shared NoC constants: flit width, port count, flit type encoding, port indices.
package noc_pkg;

    localparam int FLIT_W    = 8;
    localparam int NUM_PORTS = 5;

    localparam logic [1:0] FLIT_IDLE = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_S = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1 -: 2];
    endfunction

endpackage

// File: rtl/wormhole_sw_arbiter_if.sv
// Handshake bundle between one output's switch allocator and its crossbar/input buffers.
interface wormhole_sw_arbiter_if;
    import noc_pkg::*;

    logic [NUM_PORTS-1:0] req;
    logic [FLIT_W-1:0]    mux_flit;
    logic                 out_ready;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] read_en;
    logic                 out_valid;
    logic                 locked;
    logic                 proto_err;

    modport slave (
        input  req, mux_flit, out_ready,
        output grant, read_en, out_valid, locked, proto_err
    );

    modport master (
        output req, mux_flit, out_ready,
        input  grant, read_en, out_valid, locked, proto_err
    );

endinterface

// File: rtl/rr_pick5.sv
// Rotating-priority picker over five requesters; the port after last_winner_i is served first.
module rr_pick5 (
    input  logic [4:0] req_i,
    input  logic [2:0] last_winner_i,
    output logic [4:0] pick_o,
    output logic [2:0] idx_o
);

    logic       found;
    logic [2:0] p;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        p      = '0;
        for (int k = 1; k <= 5; k++) begin
            p = 3'((int'(last_winner_i) + k) % 5);
            if (!found && req_i[p]) begin
                found     = 1'b1;
                pick_o[p] = 1'b1;
                idx_o     = p;
            end
        end
    end

endmodule

// File: rtl/wormhole_sw_arbiter.sv
// Per-output switch allocator: round-robin grant locked from head to tail of a wormhole
// packet, with buffer pop strobes and a framing check on the muxed flit.
module wormhole_sw_arbiter
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    wormhole_sw_arbiter_if.slave bus
);

    arb_state_e           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [2:0]           last_q, last_d;
    logic [2:0]           owner_q, owner_d;
    logic                 first_q, first_d;
    logic                 perr_q, perr_d;

    logic [NUM_PORTS-1:0] pick;
    logic [2:0]           pick_idx;
    logic [1:0]           ftype;
    logic                 fire;

    rr_pick5 u_pick (
        .req_i         (bus.req),
        .last_winner_i (last_q),
        .pick_o        (pick),
        .idx_o         (pick_idx)
    );

    assign ftype = flit_type(bus.mux_flit);
    assign fire  = (state_q == ST_LOCKED) && bus.out_ready
                   && (|(bus.req & grant_q)) && (ftype != FLIT_IDLE);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        owner_d = owner_q;
        first_d = first_q;
        perr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_LOCKED;
                    grant_d = pick;
                    owner_d = pick_idx;
                    first_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (fire) begin
                    // Framing errors are flagged but never break the lock.
                    perr_d  = (first_q && ftype != FLIT_HEAD) || (!first_q && ftype == FLIT_HEAD);
                    first_d = 1'b0;
                    if (ftype == FLIT_TAIL) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                        first_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= PORT_L;
            owner_q <= PORT_N;
            first_q <= 1'b1;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            first_q <= first_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.read_en   = fire ? grant_q : '0;
    assign bus.out_valid = fire;
    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_wormhole_sw_arbiter.sv
// Directed bench for wormhole_sw_arbiter with a small input-buffer/crossbar model.
module tb_wormhole_sw_arbiter;
    import noc_pkg::*;

    logic clk;
    logic rst;
    logic [NUM_PORTS-1:0] req_v;
    logic                 rdy;
    logic                 use_man;
    logic [FLIT_W-1:0]    man_flit;
    logic [FLIT_W-1:0]    auto_flit;
    logic                 mdl_clr;
    int                   plen;
    int                   pos [NUM_PORTS];
    int                   errs;
    int                   checks;

    wormhole_sw_arbiter_if bus ();

    wormhole_sw_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] tb_type(input int p, input int len);
        if (p == 0)       return FLIT_HEAD;
        if (p == len - 1) return FLIT_TAIL;
        return FLIT_BODY;
    endfunction

    // Buffer model: each port streams packets of plen flits; the crossbar shows the granted one.
    always_comb begin
        auto_flit = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (bus.grant[i]) auto_flit = {tb_type(pos[i], plen), 6'(i)};
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mdl_clr)              pos[i] <= 0;
            else if (bus.read_en[i])  pos[i] <= (pos[i] == plen - 1) ? 0 : pos[i] + 1;
        end
    end

    assign bus.req       = req_v;
    assign bus.out_ready = rdy;
    assign bus.mux_flit  = use_man ? man_flit : auto_flit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mdl_clr = 1'b1;
        nxt();
        rst = 1'b0;
        mdl_clr = 1'b0;
    endtask

    initial begin
        errs = 0; checks = 0;
        rst = 1'b1; req_v = '0; rdy = 1'b0; use_man = 1'b0; man_flit = '0;
        plen = 3; mdl_clr = 1'b1;
        #1;
        chk("rst_grant",  32'(bus.grant), 0);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_rden",   32'(bus.read_en), 0);
        chk("rst_oval",   32'(bus.out_valid), 0);
        chk("rst_perr",   32'(bus.proto_err), 0);

        // Single 3-flit packet from port S.
        nxt(); nxt();
        rst = 1'b0; mdl_clr = 1'b0; req_v = 5'b00100; rdy = 1'b1;
        nxt(); #1;
        chk("p1_grant",  32'(bus.grant), 32'h04);
        chk("p1_locked", 32'(bus.locked), 1);
        chk("p1_rden_h", 32'(bus.read_en), 32'h04);
        chk("p1_oval_h", 32'(bus.out_valid), 1);
        nxt(); #1;
        chk("p1_rden_b", 32'(bus.read_en), 32'h04);
        chk("p1_oval_b", 32'(bus.out_valid), 1);
        chk("p1_perr",   32'(bus.proto_err), 0);
        nxt(); #1;
        chk("p1_rden_t", 32'(bus.read_en), 32'h04);
        chk("p1_oval_t", 32'(bus.out_valid), 1);
        nxt(); #1;
        chk("p1_rel_grant",  32'(bus.grant), 0);
        chk("p1_rel_locked", 32'(bus.locked), 0);
        chk("p1_rel_oval",   32'(bus.out_valid), 0);
        req_v = '0;

        // Fairness: all five request, 2-flit packets.
        do_reset();
        plen = 2; req_v = 5'b11111;
        for (int j = 0; j < 6; j++) begin
            nxt(); #1;
            chk("rr_grant", 32'(bus.grant), 32'(1) << (j % 5));
            nxt();
            nxt(); #1;
            chk("rr_bubble", 32'(bus.grant), 0);
        end
        req_v = '0;

        // Stall via out_ready mid-packet; port E owns (last winner was N).
        plen = 3; req_v = 5'b11111;
        nxt(); #1;
        chk("st_grant", 32'(bus.grant), 32'h02);
        nxt();
        rdy = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            chk("st_hold_grant", 32'(bus.grant), 32'h02);
            chk("st_hold_rden",  32'(bus.read_en), 0);
            chk("st_hold_oval",  32'(bus.out_valid), 0);
            nxt();
        end
        rdy = 1'b1; #1;
        chk("st_res_rden", 32'(bus.read_en), 32'h02);
        chk("st_res_oval", 32'(bus.out_valid), 1);
        nxt(); #1;
        chk("st_tail_rden", 32'(bus.read_en), 32'h02);
        nxt(); #1;
        chk("st_rel_grant",  32'(bus.grant), 0);
        chk("st_rel_locked", 32'(bus.locked), 0);
        req_v = '0;

        // Owner req drops between BODY flits; port N requesting must not steal the lock.
        plen = 4; req_v = 5'b00101;
        nxt(); #1;
        chk("rq_grant", 32'(bus.grant), 32'h04);
        nxt();
        nxt();
        req_v = 5'b00001; #1;
        for (int k = 0; k < 2; k++) begin
            chk("rq_hold_grant",  32'(bus.grant), 32'h04);
            chk("rq_hold_locked", 32'(bus.locked), 1);
            chk("rq_hold_oval",   32'(bus.out_valid), 0);
            nxt();
        end
        req_v = 5'b00101; #1;
        chk("rq_res_oval", 32'(bus.out_valid), 1);
        chk("rq_res_rden", 32'(bus.read_en), 32'h04);
        nxt(); #1;
        chk("rq_tail_rden", 32'(bus.read_en), 32'h04);
        nxt(); #1;
        chk("rq_rel_grant", 32'(bus.grant), 0);
        req_v = '0;

        // First fired flit is BODY: one proto_err pulse, packet still completes.
        use_man = 1'b1; man_flit = 8'b10_000011; req_v = 5'b01000;
        nxt(); #1;
        chk("pe_grant", 32'(bus.grant), 32'h08);
        chk("pe_oval",  32'(bus.out_valid), 1);
        chk("pe_perr0", 32'(bus.proto_err), 0);
        nxt();
        man_flit = 8'b11_000011; #1;
        chk("pe_perr1",  32'(bus.proto_err), 1);
        chk("pe_oval_t", 32'(bus.out_valid), 1);
        nxt(); #1;
        chk("pe_perr2",  32'(bus.proto_err), 0);
        chk("pe_locked", 32'(bus.locked), 0);
        req_v = '0;

        // TAIL as first flit: error pulse and normal release.
        req_v = 5'b00001; man_flit = 8'b11_000000;
        nxt(); #1;
        chk("tf_oval", 32'(bus.out_valid), 1);
        nxt();
        req_v = '0; #1;
        chk("tf_perr",   32'(bus.proto_err), 1);
        chk("tf_locked", 32'(bus.locked), 0);
        nxt(); #1;
        chk("tf_perr_end", 32'(bus.proto_err), 0);

        // Reset in the middle of a packet owned by port W.
        req_v = 5'b01000; man_flit = 8'b01_000011;
        nxt();
        nxt();
        man_flit = 8'b10_000011; #1;
        chk("mr_grant_pre", 32'(bus.grant), 32'h08);
        chk("mr_oval_pre",  32'(bus.out_valid), 1);
        rst = 1'b1; #1;
        chk("mr_grant",  32'(bus.grant), 0);
        chk("mr_locked", 32'(bus.locked), 0);
        chk("mr_rden",   32'(bus.read_en), 0);
        chk("mr_oval",   32'(bus.out_valid), 0);
        nxt();
        rst = 1'b0; man_flit = 8'b01_000011; #1;
        chk("mr_idle_grant", 32'(bus.grant), 0);
        nxt(); #1;
        chk("mr_regrant", 32'(bus.grant), 32'h08);
        chk("mr_relock",  32'(bus.locked), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
